// File: rtl/uart_pkg.sv
// Shared UART types and oversampling constants.
// Used by uart_receiver; the PARITY state only matters when UART_RX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 7;
    localparam int SAMPLE_END = 15;
    localparam int TICK_W     = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line.
// It resets to 1 (line idle) so that reset release cannot look like a start bit.
module uart_rx_sync (
    input  logic clock,
    input  logic Reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            meta     <= 1'b1;
            sync_out <= 1'b1;
        end else begin
            meta     <= async_in;
            sync_out <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage on a 16x oversample tick, with a valid/ack holding register.
// Define UART_RX_PARITY_EN to add a parity bit, the PARITY_ODD parameter and the ParityError port.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clock,
    input  logic                 Reset,
    input  logic                 uartClock,
    input  logic                 RxSerial,
    input  logic                 RxAck,
    output logic [DATA_BITS-1:0] RxData,
    output logic                 RxValid,
    output logic                 FramingError,
    output logic                 Overrun,
    output logic                 Busy
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 ParityError
`endif
);

    rx_state_t            state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [2:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 rx_s;
`ifdef UART_RX_PARITY_EN
    logic                 parity_bit;
`endif

    uart_rx_sync u_sync (
        .clock    (clock),
        .Reset    (Reset),
        .async_in (RxSerial),
        .sync_out (rx_s)
    );

    // A load later in this block overrides the ack-clear, so load+ack keeps RxValid high.
    always_ff @(posedge clock or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            shift_reg    <= '0;
            RxData       <= '0;
            RxValid      <= 1'b0;
            FramingError <= 1'b0;
            Overrun      <= 1'b0;
            Busy         <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            ParityError  <= 1'b0;
`endif
        end else begin
            Busy <= (state != IDLE);

            if (RxAck && RxValid) begin
                RxValid <= 1'b0;
                Overrun <= 1'b0;
            end

            if (uartClock) begin
                case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                        end
                    end

                    START: begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_W'(SAMPLE_MID)) begin
                            tick_cnt <= '0;
                            if (!rx_s) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end

                    DATA: begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_W'(SAMPLE_END)) begin
                            shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end

`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_W'(SAMPLE_END)) begin
                            parity_bit <= rx_s;
                            state      <= STOP;
                        end
                    end
`endif

                    STOP: begin
                        tick_cnt <= tick_cnt + TICK_W'(1);
                        if (tick_cnt == TICK_W'(SAMPLE_END)) begin
                            RxData       <= shift_reg;
                            FramingError <= ~rx_s;
                            RxValid      <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            ParityError  <= ((^shift_reg) ^ parity_bit) != PARITY_ODD;
`endif
                            if (RxValid && !RxAck) begin
                                Overrun <= 1'b1;
                            end
                            state <= rx_s ? IDLE : WAIT_IDLE;
                        end
                    end

                    // A held-low line (break) must not start a new frame.
                    WAIT_IDLE: begin
                        if (rx_s) begin
                            state <= IDLE;
                        end
                    end

                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed frames against a holding-register model.
module tb_uart_receiver;

    localparam int DATA_BITS = 8;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_TICKS  = 16;
    localparam bit PARITY_ODD = 1'b0;
`else
    localparam int PAR_TICKS  = 0;
`endif
    localparam int FRAME_TICKS = 16 * (DATA_BITS + 2) + PAR_TICKS;
    // Ticks after the start edge at which the stop bit is sampled and the byte loads.
    localparam int LOAD_TICK   = 16 * DATA_BITS + 25 + PAR_TICKS;

    logic       clock = 1'b0;
    logic       Reset;
    logic       uartClock = 1'b0;
    logic       RxSerial;
    logic       RxAck;
    logic [7:0] RxData;
    logic       RxValid;
    logic       FramingError;
    logic       Overrun;
    logic       Busy;
`ifdef UART_RX_PARITY_EN
    logic       ParityError;
`endif

    logic [1:0] div = 2'd0;

    bit         m_valid;
    bit         m_ovr;
    bit         m_fe;
    bit         m_pe;
    logic [7:0] m_data;
    bit         cmp_en = 1'b0;

    int vecCount = 0;
    int errCount = 0;

    uart_receiver #(.DATA_BITS(DATA_BITS)) dut (
        .clock        (clock),
        .Reset        (Reset),
        .uartClock    (uartClock),
        .RxSerial     (RxSerial),
        .RxAck        (RxAck),
        .RxData       (RxData),
        .RxValid      (RxValid),
        .FramingError (FramingError),
        .Overrun      (Overrun),
        .Busy         (Busy)
`ifdef UART_RX_PARITY_EN
        ,
        .ParityError  (ParityError)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        div       <= div + 2'd1;
        uartClock <= (div == 2'd3);
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        vecCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clock) begin
        if (cmp_en) begin
            checkOutput("valid", 8'(RxValid), 8'(m_valid));
            checkOutput("overrun", 8'(Overrun), 8'(m_ovr));
            if (m_valid) begin
                checkOutput("data", RxData, m_data);
                checkOutput("framing", 8'(FramingError), 8'(m_fe));
`ifdef UART_RX_PARITY_EN
                checkOutput("parity", 8'(ParityError), 8'(m_pe));
`endif
            end
        end
    end

    task automatic waitTicks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            while (!uartClock) @(posedge clock);
        end
        #1;
    endtask

    task automatic modelLoad(input logic [7:0] data, input bit stop_bit, input bit ack, input bit bad_par);
        if (m_valid && ack)
            m_ovr = 1'b0;
        else if (m_valid)
            m_ovr = 1'b1;
        m_valid = 1'b1;
        m_data  = data;
        m_fe    = ~stop_bit;
        m_pe    = bad_par;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit stop_bit, input bit ack_at_load, input bit bad_par);
        logic [10:0] lv;
        lv    = '1;
        lv[0] = 1'b0;
        for (int j = 0; j < DATA_BITS; j++) lv[j+1] = data[j];
`ifdef UART_RX_PARITY_EN
        lv[DATA_BITS+1] = (^data) ^ PARITY_ODD ^ bad_par;
        lv[DATA_BITS+2] = stop_bit;
`else
        lv[DATA_BITS+1] = stop_bit;
`endif
        RxSerial = 1'b0;
        for (int i = 1; i <= FRAME_TICKS; i++) begin
            if (i == LOAD_TICK && ack_at_load) begin
                @(negedge clock);
                while (!uartClock) @(negedge clock);
                RxAck = 1'b1;
            end
            waitTicks(1);
            if (i == LOAD_TICK) begin
                modelLoad(data, stop_bit, ack_at_load, bad_par);
                RxAck = 1'b0;
            end
            if (i == 64) checkOutput("busy_mid", 8'(Busy), 8'd1);
            if (i < FRAME_TICKS) RxSerial = lv[i/16];
        end
        RxSerial = stop_bit;
    endtask

    task automatic ackFrame();
        @(negedge clock);
        RxAck = 1'b1;
        @(posedge clock);
        #1;
        if (m_valid) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        RxAck = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        Reset    = 1'b0;
        RxSerial = 1'b1;
        RxAck    = 1'b0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_fe     = 1'b0;
        m_pe     = 1'b0;
        m_data   = 8'h00;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("rst_valid", 8'(RxValid), 8'd0);
        checkOutput("rst_data", RxData, 8'h00);
        checkOutput("rst_fe", 8'(FramingError), 8'd0);
        checkOutput("rst_ovr", 8'(Overrun), 8'd0);
        checkOutput("rst_busy", 8'(Busy), 8'd0);
        Reset  = 1'b1;
        cmp_en = 1'b1;
        waitTicks(4);

        $display("[TB] 8N1 byte 0xA5");
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0);
        waitTicks(4);
        checkOutput("a5_data", RxData, 8'hA5);
        checkOutput("a5_valid", 8'(RxValid), 8'd1);
        checkOutput("a5_fe", 8'(FramingError), 8'd0);
        checkOutput("a5_busy", 8'(Busy), 8'd0);
        ackFrame();

        $display("[TB] 4-tick glitch");
        RxSerial = 1'b0;
        waitTicks(4);
        RxSerial = 1'b1;
        waitTicks(2);
        checkOutput("glitch_busy", 8'(Busy), 8'd1);
        waitTicks(20);
        checkOutput("glitch_idle", 8'(Busy), 8'd0);
        checkOutput("glitch_valid", 8'(RxValid), 8'd0);

        $display("[TB] break after 0x3C");
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        waitTicks(40);
        checkOutput("brk_busy", 8'(Busy), 8'd1);
        checkOutput("brk_data", RxData, 8'h3C);
        checkOutput("brk_fe", 8'(FramingError), 8'd1);
        checkOutput("brk_ovr", 8'(Overrun), 8'd0);
        RxSerial = 1'b1;
        waitTicks(4);
        checkOutput("brk_idle", 8'(Busy), 8'd0);
        ackFrame();

        $display("[TB] overrun 0x11 then 0x22");
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
        waitTicks(2);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0);
        waitTicks(2);
        checkOutput("ovr_data", RxData, 8'h22);
        checkOutput("ovr_flag", 8'(Overrun), 8'd1);
        ackFrame();
        checkOutput("ovr_valid_clr", 8'(RxValid), 8'd0);
        checkOutput("ovr_flag_clr", 8'(Overrun), 8'd0);

        $display("[TB] ack on load cycle");
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0);
        waitTicks(2);
        applyStimulus(8'h22, 1'b1, 1'b1, 1'b0);
        waitTicks(2);
        checkOutput("sim_data", RxData, 8'h22);
        checkOutput("sim_valid", 8'(RxValid), 8'd1);
        checkOutput("sim_ovr", 8'(Overrun), 8'd0);
        ackFrame();

        $display("[TB] reset during bit 3 of 0xFF");
        RxSerial = 1'b0;
        waitTicks(16);
        RxSerial = 1'b1;
        waitTicks(56);
        checkOutput("rstmid_busy", 8'(Busy), 8'd1);
        Reset   = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 1'b0;
        m_pe    = 1'b0;
        m_data  = 8'h00;
        repeat (2) @(posedge clock);
        #1;
        Reset = 1'b1;
        waitTicks(2);
        checkOutput("rstmid_idle", 8'(Busy), 8'd0);
        waitTicks(120);
        checkOutput("rstmid_nodata", 8'(RxValid), 8'd0);
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b0);
        waitTicks(4);
        checkOutput("rst_81_data", RxData, 8'h81);
        checkOutput("rst_81_valid", 8'(RxValid), 8'd1);
        ackFrame();

`ifdef UART_RX_PARITY_EN
        $display("[TB] 0x81 with parity bit 1");
        applyStimulus(8'h81, 1'b1, 1'b0, 1'b1);
        waitTicks(4);
        checkOutput("par_err", 8'(ParityError), 8'd1);
        ackFrame();
`endif

        waitTicks(4);
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage fed by the baud-rate generator's 16x oversample tick (`uartClock`, one system-clock-wide pulse). Synchronises the asynchronous `RxSerial` line, detects and validates start bits at mid-bit, shifts in LSB-first data, and checks the stop bit. Presents each received byte in a holding register with a valid/ack handshake to the downstream consumer, with framing and overrun status.

## Interface
- `DATA_BITS`, default 8: data bits per frame, legal range 5–8.
- `PARITY_ODD`, default 0: only used with `UART_RX_PARITY_EN`; 1 selects odd parity, 0 selects even.
- `clock` input 1: system clock; everything is on `posedge clock`.
- `Reset` input 1: asynchronous, active-low reset.
- `uartClock` input 1: 16x oversample tick from the baud-rate generator, one cycle wide.
- `RxSerial` input 1: raw serial line; idles high.
- `RxAck` input 1: consumer accepts the holding register.
- `RxData` output `DATA_BITS`: received byte, LSB is the first bit on the line.
- `RxValid` output 1: holding register full.
- `FramingError` output 1: the frame in the holding register had stop bit = 0.
- `Overrun` output 1: sticky; a frame completed while `RxValid` = 1 and no ack arrived.
- `Busy` output 1: the state machine is not in IDLE.
- `ParityError` output 1: present only with `UART_RX_PARITY_EN`.

## Operation
- `RxSerial` passes through a 2-flop synchronizer; the FSM sees only the synchronized value `rx_s`.
- The FSM advances only on cycles where `uartClock` = 1. `tick_cnt` is 4 bits and `bit_cnt` is 3 bits.
- **IDLE**: if `rx_s` = 0 on a tick, go to START with `tick_cnt` = 0.
- **START**: increment `tick_cnt` each tick. At `tick_cnt` = 7 (mid-bit):
  - `rx_s` = 0: go to DATA with `tick_cnt` = 0 and `bit_cnt` = 0.
  - `rx_s` = 1: false start; return to IDLE with no flags set.
- **DATA**: at `tick_cnt` = 15, shift `rx_s` into the MSB of the shift register (right shift) and increment `bit_cnt`. `tick_cnt` wraps 15 to 0. After `DATA_BITS` samples, go to PARITY (macro) or STOP.
- **PARITY**: at `tick_cnt` = 15, sample the parity bit, then go to STOP.
- **STOP**: at `tick_cnt` = 15, sample the stop bit, then load the holding register.
  - Stop bit = 1: go to IDLE.
  - Stop bit = 0: go to WAIT_IDLE.
- **WAIT_IDLE**: go to IDLE on the first tick with `rx_s` = 1. This prevents a break condition from retriggering frames.
- **Load**: on load, `RxData` takes the shift register, `FramingError` takes the inverted stop bit, and `ParityError` takes the parity check result. `RxValid` is set to 1.
- **Handshake**:
  - `RxAck` with `RxValid` = 1 clears `RxValid` and `Overrun` on the next edge.
  - `RxAck` with `RxValid` = 0 is ignored.
- **Overrun**: when a load occurs with `RxValid` = 1 and no `RxAck` in the same cycle, the new frame overwrites the holding register and `Overrun` is set.
- **Simultaneous load and ack**: the new data is loaded, `RxValid` stays 1, and `Overrun` is not set.
- **Reset**: asserting `Reset` mid-frame aborts the frame immediately. After release the FSM is in IDLE and the partial frame is discarded.

## Timing
- All outputs reset to 0: `RxData`, `RxValid`, `FramingError`, `Overrun`, `Busy`, `ParityError`. The state resets to IDLE and both counters to 0. The synchronizer flops reset to 1.
- Input latency: 2 clocks from `RxSerial` to `rx_s`.
- `RxValid` rises 1 clock after the tick at which the stop bit is sampled.
- Frame length in ticks: 8 (start) + 16·`DATA_BITS` + 16 (stop), plus 16 with parity.
- `Busy` is registered and goes high 1 clock after the IDLE→START transition.
- `RxData` and the flags stay stable while `RxValid` = 1, except when an overwrite occurs.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - PARITY state, `PARITY_ODD` parameter and `ParityError` port all exist.
  - `ParityError` = 1 when the XOR of the data bits and the parity bit ≠ `PARITY_ODD`.
- `UART_RX_PARITY_EN` not defined:
  - No PARITY state and no `ParityError` port.
  - STOP directly follows the last data bit (8N1 framing).

## Structure
- Package `uart_pkg`:
  - `rx_state_t` enum: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - Constants `OVERSAMPLE` = 16, `SAMPLE_MID` = 7, `SAMPLE_END` = 15.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1. It is reused by future transmit/CTS logic.

## Test plan
- 8N1 byte 0xA5 sent at tick rate, `RxAck` held 0 → `RxValid` = 1, `RxData` = 0xA5, `FramingError` = 0, `Busy` low after the stop bit.
- 4-tick low glitch on an idle line → FSM returns to IDLE, `RxValid` stays 0, no flags.
- Frame 0x3C with stop bit = 0, line then held low for 40 ticks → `RxData` = 0x3C, `FramingError` = 1, no second frame until the line goes high.
- Bytes 0x11 then 0x22 with no ack → `RxData` = 0x22, `Overrun` = 1; a later `RxAck` clears both `RxValid` and `Overrun`.
- `RxAck` asserted on the exact load cycle of the second byte → `RxData` = 0x22, `RxValid` = 1, `Overrun` = 0.
- `Reset` pulsed low during bit 3 of 0xFF, then 0x81 sent → only 0x81 is delivered. With the macro and `PARITY_ODD` = 0, sending 0x81 with parity bit 1 gives `ParityError` = 1.
